pc_fetch_stage: RTL and testbench

- Fetch stage directly downstream of the next-PC select mux in the jump-capable datapath.
- Holds the PC register and exports pc_plus4 to the mux's sequential input. Loads the mux's selected next PC.
- Runs a req/valid handshake with instruction memory and drives the IF/ID register toward decode, with stall, skid and redirect-flush handling.

---
 rtl/pc_fetch_stage_if.sv | 32 +++
 rtl/pc_fetch_stage.sv | 172 +++++++++++++++++
 tb/tb_pc_fetch_stage.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_stage_if.sv
// pc_fetch_stage_if: bundles the fetch stage's PC-mux, instruction-memory and
// decode-side signals. The master modport is the fetch stage itself. The slave
// modport is its surroundings: the PC mux, the instruction memory and decode.
interface pc_fetch_stage_if #(
    parameter int N = 32
);
    logic [N-1:0] next_pc;
    logic         redirect;
    logic [N-1:0] pc;
    logic [N-1:0] pc_plus4;
    logic         imem_req;
    logic [N-1:0] imem_addr;
    logic         imem_valid;
    logic [N-1:0] imem_rdata;
    logic         id_stall;
    logic         if_valid;
    logic [N-1:0] if_pc;
    logic [N-1:0] if_instr;
    logic         misalign_err;

    modport master (
        input  next_pc, redirect, imem_valid, imem_rdata, id_stall,
        output pc, pc_plus4, imem_req, imem_addr, if_valid, if_pc, if_instr,
               misalign_err
    );

    modport slave (
        output next_pc, redirect, imem_valid, imem_rdata, id_stall,
        input  pc, pc_plus4, imem_req, imem_addr, if_valid, if_pc, if_instr,
               misalign_err
    );
endinterface

// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage: the PC register and fetch stage that sit behind the next-PC mux.
// - Runs a single-outstanding req/valid handshake with instruction memory.
// - Fills the IF/ID register, using a one-entry skid buffer while decode stalls.
// - A redirect flushes the stage. A response that is still in flight when the
//   redirect arrives is drained in DROP.
// Optional macro FETCH_ALIGN_CHECK_EN: loading a misaligned PC traps into ERR.
// Without the macro, the low two bits of every loaded PC are cleared instead.
module pc_fetch_stage #(
    parameter int           N         = 32,
    parameter logic [N-1:0] RESET_PC  = '0,
    parameter logic [N-1:0] NOP_INSTR = N'(32'h0000_0013)
) (
    input  logic              clk,
    input  logic              rst,
    pc_fetch_stage_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_HOLD, S_DROP
`ifdef FETCH_ALIGN_CHECK_EN
        , S_ERR
`endif
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] pc_q, pc_d;
    logic [N-1:0] drop_addr_q, drop_addr_d;
    logic         if_valid_q, if_valid_d;
    logic [N-1:0] if_pc_q, if_pc_d;
    logic [N-1:0] if_instr_q, if_instr_d;
    logic [N-1:0] skid_pc_q, skid_pc_d;
    logic [N-1:0] skid_instr_q, skid_instr_d;
    logic         slot_free, consumed, flush;
    logic [N-1:0] next_pc_ld;

    assign slot_free = !if_valid_q || !bus.id_stall;
    assign consumed  = if_valid_q && !bus.id_stall;

`ifdef FETCH_ALIGN_CHECK_EN
    assign next_pc_ld = bus.next_pc;
`else
    assign next_pc_ld = bus.next_pc & ~N'(3);
`endif

    // Next-state logic: handshake progress, IF/ID and skid movement, and redirect flush.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_addr_d  = drop_addr_q;
        if_valid_d   = if_valid_q;
        if_pc_d      = if_pc_q;
        if_instr_d   = if_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        flush        = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.redirect) begin
                    pc_d  = next_pc_ld;
                    flush = 1'b1;
                    // A request is still in flight, so its late response must be drained.
                    if (!bus.imem_valid) begin
                        state_d     = S_DROP;
                        drop_addr_d = pc_q;
                    end
                end else if (bus.imem_valid) begin
                    pc_d = next_pc_ld;
                    if (slot_free) begin
                        if_valid_d = 1'b1;
                        if_pc_d    = pc_q;
                        if_instr_d = bus.imem_rdata;
                    end else begin
                        skid_pc_d    = pc_q;
                        skid_instr_d = bus.imem_rdata;
                        state_d      = S_HOLD;
                    end
                end else if (consumed) begin
                    if_valid_d = 1'b0;
                    if_instr_d = NOP_INSTR;
                end
            end
            S_HOLD: begin
                if (bus.redirect) begin
                    pc_d    = next_pc_ld;
                    flush   = 1'b1;
                    state_d = S_WAIT;
                end else if (slot_free) begin
                    if_valid_d   = 1'b1;
                    if_pc_d      = skid_pc_q;
                    if_instr_d   = skid_instr_q;
                    skid_pc_d    = '0;
                    skid_instr_d = '0;
                    state_d      = S_WAIT;
                end
            end
            S_DROP: begin
                if (bus.redirect) begin
                    pc_d  = next_pc_ld;
                    flush = 1'b1;
                end else if (consumed) begin
                    if_valid_d = 1'b0;
                    if_instr_d = NOP_INSTR;
                end
                if (bus.imem_valid) state_d = S_WAIT;
            end
`ifdef FETCH_ALIGN_CHECK_EN
            S_ERR: begin
                if (bus.redirect) begin
                    pc_d    = next_pc_ld;
                    state_d = S_WAIT;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

`ifdef FETCH_ALIGN_CHECK_EN
        // PC is only ever misaligned right after a bad load, or while sitting in ERR.
        if (pc_d[1:0] != 2'b00) begin
            state_d = S_ERR;
            flush   = 1'b1;
        end
`endif

        if (flush) begin
            if_valid_d   = 1'b0;
            if_instr_d   = NOP_INSTR;
            skid_pc_d    = '0;
            skid_instr_d = '0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            drop_addr_q  <= RESET_PC;
            if_valid_q   <= 1'b0;
            if_pc_q      <= '0;
            if_instr_q   <= NOP_INSTR;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_addr_q  <= drop_addr_d;
            if_valid_q   <= if_valid_d;
            if_pc_q      <= if_pc_d;
            if_instr_q   <= if_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.pc_plus4  = pc_q + N'(4);
    assign bus.imem_req  = (state_q == S_WAIT) || (state_q == S_DROP);
    // While draining, keep presenting the address of the request still in flight.
    assign bus.imem_addr = (state_q == S_DROP) ? drop_addr_q : pc_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_pc     = if_pc_q;
    assign bus.if_instr  = if_instr_q;
`ifdef FETCH_ALIGN_CHECK_EN
    assign bus.misalign_err = (state_q == S_ERR);
`else
    assign bus.misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb_pc_fetch_stage: cycle table, directed corner sequences and a randomized run.
// The randomized run checks the stream decode consumes against an
// architectural PC sequence model.
module tb_pc_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_fetch_stage_if #(.N(32)) bus ();
    pc_fetch_stage #(.N(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    int tests = 0;
    int fails = 0;

    // memory model: one request at a time, response mem_lat+1 cycles after the req is seen
    bit          m_pend;
    int          m_cnt;
    logic [31:0] m_addr;
    int          mem_lat = 0;
    bit          lat_rand = 0;
    bit          ovr_en = 0;
    logic [31:0] ovr_addr, ovr_data;
    logic        s_req;
    logic [31:0] s_addr;

    // architectural model: PC of the next instruction decode should consume
    bit          chk_en = 0;
    logic [31:0] exp_pc;
    int          ncons;

    typedef struct {
        bit          rd;
        logic [31:0] tgt;
        bit          stall;
        logic        req;
        logic [31:0] addr;
        logic        ifv;
        logic [31:0] ifpc;
        logic [31:0] instr;
        logic [31:0] pp4;
    } vec_t;
    vec_t tbl[12];

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (ovr_en && a == ovr_addr) return ovr_data;
        return a ^ 32'h0000_0093;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // drive inputs for this cycle, sample memory-facing outputs, run model checks
    task automatic drive(input bit rd, input logic [31:0] tgt, input bit stall);
        bus.redirect = rd;
        bus.id_stall = stall;
        bus.next_pc  = rd ? tgt : bus.pc_plus4;
        #1;
        s_req  = bus.imem_req;
        s_addr = bus.imem_addr;
        if (chk_en) begin
            chk("pc_plus4", bus.pc_plus4, bus.pc + 32'd4);
            if (!bus.if_valid) chk("empty_instr", bus.if_instr, NOP);
            else if (!stall) begin
                chk("cons_pc", bus.if_pc, exp_pc);
                chk("cons_instr", bus.if_instr, mem_data(exp_pc));
                exp_pc = exp_pc + 32'd4;
                ncons++;
            end
            if (rd) exp_pc = tgt;
        end
    endtask

    task automatic clock();
        int l;
        @(posedge clk);
        #1;
        if (bus.imem_valid) bus.imem_valid = 1'b0;
        else if (m_pend) begin
            if (m_cnt == 0) begin
                m_pend = 0;
                bus.imem_valid = 1'b1;
                bus.imem_rdata = mem_data(m_addr);
            end else m_cnt--;
        end else if (s_req) begin
            l = lat_rand ? int'($urandom_range(0, 3)) : mem_lat;
            m_addr = s_addr;
            if (l == 0) begin
                bus.imem_valid = 1'b1;
                bus.imem_rdata = mem_data(m_addr);
            end else begin
                m_pend = 1;
                m_cnt  = l - 1;
            end
        end
    endtask

    task automatic cyc(input bit rd, input logic [31:0] tgt, input bit stall);
        drive(rd, tgt, stall);
        clock();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.imem_valid = 1'b0;
        bus.imem_rdata = '0;
        bus.redirect = 1'b0;
        bus.id_stall = 1'b0;
        bus.next_pc = '0;
        m_pend = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_deliver(input string nm);
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 32'h0, 1'b0);
            if (bus.if_valid) begin
                ok = 1;
                break;
            end
        end
        chk({nm, "_timeout"}, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        //              rd tgt    st req addr   ifv ifpc  instr  pp4
        tbl[0]  = '{0, 32'h0,  0, 0, 32'h0,  0, 32'h0,  NOP,   32'h4};
        tbl[1]  = '{0, 32'h0,  0, 1, 32'h0,  0, 32'h0,  NOP,   32'h4};
        tbl[2]  = '{0, 32'h0,  0, 1, 32'h0,  0, 32'h0,  NOP,   32'h4};
        tbl[3]  = '{0, 32'h0,  0, 1, 32'h4,  1, 32'h0,  32'h93, 32'h8};
        tbl[4]  = '{0, 32'h0,  0, 1, 32'h4,  0, 32'h0,  NOP,   32'h8};
        tbl[5]  = '{0, 32'h0,  0, 1, 32'h8,  1, 32'h4,  32'h97, 32'hC};
        tbl[6]  = '{0, 32'h0,  0, 1, 32'h8,  0, 32'h0,  NOP,   32'hC};
        tbl[7]  = '{0, 32'h0,  0, 1, 32'hC,  1, 32'h8,  32'h9B, 32'h10};
        tbl[8]  = '{1, 32'h40, 0, 1, 32'hC,  0, 32'h0,  NOP,   32'h10};
        tbl[9]  = '{0, 32'h0,  0, 1, 32'h40, 0, 32'h0,  NOP,   32'h44};
        tbl[10] = '{0, 32'h0,  0, 1, 32'h40, 0, 32'h0,  NOP,   32'h44};
        tbl[11] = '{0, 32'h0,  0, 1, 32'h44, 1, 32'h40, 32'hD3, 32'h48};

        // reset state
        do_reset();
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_ifv", {31'd0, bus.if_valid}, 32'd0);
        chk("rst_ifpc", bus.if_pc, 32'h0);
        chk("rst_instr", bus.if_instr, NOP);
        chk("rst_err", {31'd0, bus.misalign_err}, 32'd0);

        // cycle table: first fetch, back-to-back fetches, redirect colliding with a response
        for (int k = 0; k < 12; k++) begin
            drive(tbl[k].rd, tbl[k].tgt, tbl[k].stall);
            tests++;
            if (bus.imem_req !== tbl[k].req || bus.imem_addr !== tbl[k].addr ||
                bus.if_valid !== tbl[k].ifv || (tbl[k].ifv && bus.if_pc !== tbl[k].ifpc) ||
                bus.if_instr !== tbl[k].instr || bus.pc_plus4 !== tbl[k].pp4) begin
                fails++;
                $display("FAIL vec%0d: got req=%b addr=%h v=%b pc=%h instr=%h pp4=%h expected req=%b addr=%h v=%b pc=%h instr=%h pp4=%h",
                         k, bus.imem_req, bus.imem_addr, bus.if_valid, bus.if_pc, bus.if_instr, bus.pc_plus4,
                         tbl[k].req, tbl[k].addr, tbl[k].ifv, tbl[k].ifpc, tbl[k].instr, tbl[k].pp4);
            end
            clock();
        end

        // a response strobe while IDLE is ignored
        do_reset();
        drive(1'b0, 32'h0, 1'b0);
        bus.imem_valid = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        clock();
        chk("idle_ignore_v", {31'd0, bus.if_valid}, 32'd0);
        wait_deliver("idle");
        chk("idle_first_pc", bus.if_pc, 32'h0);
        chk("idle_first_instr", bus.if_instr, 32'h93);

        // stall with a response arriving goes to HOLD, then releases the skid entry
        do_reset();
        ovr_en = 1; ovr_addr = 32'h4; ovr_data = 32'hAAAA_AAAA;
        repeat (3) cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1);
        cyc(1'b0, 32'h0, 1'b1);
        chk("hold_req", {31'd0, bus.imem_req}, 32'd0);
        chk("hold_instr", bus.if_instr, 32'h93);
        cyc(1'b0, 32'h0, 1'b1);
        chk("hold_req2", {31'd0, bus.imem_req}, 32'd0);
        cyc(1'b0, 32'h0, 1'b0);
        chk("skid_instr", bus.if_instr, 32'hAAAA_AAAA);
        chk("skid_pc", bus.if_pc, 32'h4);
        chk("skid_next_addr", bus.imem_addr, 32'h8);
        ovr_en = 0;

        // redirect with a request outstanding: stale response is drained
        mem_lat = 2;
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b1, 32'h100, 1'b0);
        chk("redir_flush", {31'd0, bus.if_valid}, 32'd0);
        chk("drop_addr", bus.imem_addr, 32'h8);
        wait_deliver("drop");
        chk("drop_first_pc", bus.if_pc, 32'h100);
        chk("drop_first_instr", bus.if_instr, 32'h0000_0193);

        // pc_plus4 wraps modulo 2^32
        cyc(1'b1, 32'hFFFF_FFFC, 1'b0);
        chk("wrap_pc", bus.pc, 32'hFFFF_FFFC);
        chk("wrap_pp4", bus.pc_plus4, 32'h0);
        wait_deliver("wrap");
        chk("wrap_if_pc", bus.if_pc, 32'hFFFF_FFFC);
        chk("wrap_next_pc", bus.pc, 32'h0);

        // misaligned redirect
        mem_lat = 0;
        do_reset();
        repeat (3) cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b1, 32'h102, 1'b0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("mis_err", {31'd0, bus.misalign_err}, 32'd1);
        chk("mis_req", {31'd0, bus.imem_req}, 32'd0);
        chk("mis_ifv", {31'd0, bus.if_valid}, 32'd0);
        cyc(1'b1, 32'h104, 1'b0);
        chk("mis_clear", {31'd0, bus.misalign_err}, 32'd0);
        chk("mis_req2", {31'd0, bus.imem_req}, 32'd1);
        chk("mis_addr", bus.imem_addr, 32'h104);
        wait_deliver("mis");
        chk("mis_first_pc", bus.if_pc, 32'h104);
`else
        chk("mis_err", {31'd0, bus.misalign_err}, 32'd0);
        chk("mis_pc_forced", bus.pc, 32'h100);
        wait_deliver("mis");
        chk("mis_first_pc", bus.if_pc, 32'h100);
`endif

        // randomized run against the architectural stream model
        do_reset();
        lat_rand = 1;
        exp_pc = 32'h0;
        ncons = 0;
        chk_en = 1;
        for (int i = 0; i < 4000; i++) begin
            bit          rd;
            bit          st;
            logic [31:0] tgt;
            rd  = (i > 2) && ($urandom_range(0, 99) < 4);
            st  = ($urandom_range(0, 99) < 30);
            tgt = 32'($urandom_range(0, 16383)) << 2;
            cyc(rd, tgt, st);
        end
        chk_en = 0;
        chk("rand_progress", {31'd0, ncons > 200}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
